sd_spi_card_responder: RTL and testbench

- SPI-mode SD card responder: the card side of the SD initialization protocol. It receives SCLK/CS/DI from a host and drives DO.
- It decodes 48-bit command frames and returns R1, R3 or R7 responses for CMD0, CMD8, CMD55, ACMD41, CMD58 and CMD16.
- It tracks the card state through UNINIT, IDLE and READY.
- Used as an on-chip card model to exercise the SD host initializer in simulation and on the board, and as the base for a later data-block responder.

---
 rtl/sd_pkg.sv | 10 +
 rtl/sd_crc7.sv | 14 +
 rtl/sd_spi_card_responder.sv | 195 +++++++++++++++++++
 tb/tb_sd_spi_card_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD SPI command, response and state definitions
package sd_pkg;
  typedef enum logic [1:0] {ST_UNINIT = 2'd0, ST_IDLE = 2'd1, ST_READY = 2'd2} card_state_e;
  typedef enum logic [2:0] {HUNT, RECV, DECODE, NCR, RESP} rx_state_e;
  localparam logic [5:0] CMD0 = 6'd0, CMD8 = 6'd8, CMD16 = 6'd16, CMD41 = 6'd41, CMD55 = 6'd55, CMD58 = 6'd58;
  localparam int R1_IDLE = 0, R1_ILLEGAL = 2, R1_CRC = 3, R1_PARAM = 6;
  localparam logic [31:0] OCR_BASE = 32'h00FF8000;
  localparam int FRAME_LEN = 48;
  localparam logic [6:0] CRC7_POLY = 7'h09;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1) accumulator with clear and bit enable
module sd_crc7 import sd_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  logic [6:0] crc_q, crc_d;
  always_comb crc_d = clr ? '0 : en ? ({crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ din) ? CRC7_POLY : 7'h0)) : crc_q;
  always_ff @(posedge clk) crc_q <= reset ? '0 : crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card side of the initialization handshake
module sd_spi_card_responder import sd_pkg::*; #(
  parameter int ACMD41_BUSY = 2,
  parameter int CCS         = 1,
  parameter int NCR_BYTES   = 1,
  parameter int CHECK_CRC   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        DI,
  output logic        DO,
  output logic        cmdValid,
  output logic [5:0]  cmdIndex,
  output logic [31:0] cmdArgument,
  output logic [1:0]  cardState
);
  logic [2:0] sclk_q;
  logic [1:0] cs_q, di_q;
  logic rise, fall, cs_hi, din;
  rx_state_e state_q, state_d;
  card_state_e card_q, card_d, card_n;
  logic [47:0] frame_q, frame_d;
  logic [39:0] resp_q, resp_d;
  logic [6:0] cnt_q, cnt_d, resp_len;
  logic long_q, long_d, long_n;
  logic do_q, do_d, valid_q, valid_d, app_q, app_d, app_n;
  logic [7:0] busy_q, busy_d, busy_n, r1;
  logic [5:0] idx_q, idx_d, f_idx;
  logic [31:0] arg_q, arg_d, f_arg, tail;
  logic [6:0] crc;
  logic frame_ok, crc_bad, respond, last_ncr, illegal, perr;
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q <= 2'b11;
      di_q <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      cs_q <= {cs_q[0], CS};
      di_q <= {di_q[0], DI};
    end
  end
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign fall = ~sclk_q[1] & sclk_q[2];
  assign cs_hi = cs_q[1];
  assign din = di_q[1];
  sd_crc7 u_crc7 (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == HUNT),
    .en   (!cs_hi && state_q == RECV && rise && cnt_q < 7'd40),
    .din  (din),
    .crc  (crc)
  );
  assign f_idx = frame_q[45:40];
  assign f_arg = frame_q[39:8];
  assign frame_ok = !frame_q[47] && frame_q[46] && frame_q[0];
  assign crc_bad = (CHECK_CRC != 0) && (crc != frame_q[7:1]);
  assign respond = frame_ok && (card_q != ST_UNINIT || f_idx == CMD0);
  assign last_ncr = cnt_q == 7'(NCR_BYTES * 8 - 1);
  assign resp_len = long_q ? 7'd40 : 7'd8;
  always_comb begin
    card_n = card_q;
    app_n = f_idx == CMD55;
    busy_n = busy_q;
    illegal = 1'b0;
    perr = 1'b0;
    long_n = 1'b0;
    tail = '0;
    if (crc_bad) app_n = app_q;
    else case (f_idx)
      CMD0: begin
        card_n = ST_IDLE;
        busy_n = 8'(ACMD41_BUSY);
      end
      CMD8: begin
        long_n = 1'b1;
        tail = {20'h0, (f_arg[11:8] == 4'h1) ? 4'h1 : 4'h0, f_arg[7:0]};
      end
      CMD55: app_n = 1'b1;
      CMD41: begin
        if (!app_q) illegal = 1'b1;
        else if (busy_q != 8'd0) busy_n = busy_q - 8'd1;
        else card_n = ST_READY;
      end
      CMD58: begin
        long_n = 1'b1;
        tail = OCR_BASE | {card_q == ST_READY, card_q == ST_READY && CCS != 0, 30'h0};
      end
      CMD16: perr = f_arg != 32'h0000_0200;
      default: illegal = 1'b1;
    endcase
    r1 = '0;
    r1[R1_IDLE] = card_n != ST_READY;
    r1[R1_ILLEGAL] = illegal;
    r1[R1_CRC] = crc_bad;
    r1[R1_PARAM] = perr;
  end
  always_ff @(posedge clk) state_q <= reset ? HUNT : state_d;
  always_comb begin
    state_d = state_q;
    if (cs_hi) state_d = HUNT;
    else case (state_q)
      HUNT:    state_d = (rise && !din) ? RECV : HUNT;
      RECV:    state_d = (rise && cnt_q == 7'(FRAME_LEN - 1)) ? DECODE : RECV;
      DECODE:  state_d = respond ? NCR : HUNT;
      NCR:     state_d = (fall && last_ncr) ? RESP : NCR;
      RESP:    state_d = (fall && cnt_q == resp_len) ? HUNT : RESP;
      default: state_d = HUNT;
    endcase
  end
  always_comb begin
    frame_d = frame_q;
    resp_d = resp_q;
    cnt_d = cnt_q;
    long_d = long_q;
    do_d = do_q;
    valid_d = 1'b0;
    card_d = card_q;
    app_d = app_q;
    busy_d = busy_q;
    idx_d = idx_q;
    arg_d = arg_q;
    if (cs_hi) begin
      do_d = 1'b1;
      cnt_d = '0;
    end else case (state_q)
      HUNT: if (rise && !din) begin
        cnt_d = 7'd1;
        frame_d = '0;
      end
      RECV: if (rise) begin
        frame_d = {frame_q[46:0], din};
        cnt_d = cnt_q + 7'd1;
      end
      DECODE: begin
        cnt_d = '0;
        if (respond) begin
          valid_d = 1'b1;
          idx_d = f_idx;
          arg_d = f_arg;
          card_d = card_n;
          app_d = app_n;
          busy_d = busy_n;
          long_d = long_n;
          resp_d = {r1, tail};
        end
      end
      NCR: if (fall) begin
        do_d = 1'b1;
        cnt_d = last_ncr ? '0 : cnt_q + 7'd1;
      end
      RESP: if (fall) begin
        do_d = (cnt_q == resp_len) ? 1'b1 : resp_q[39];
        resp_d = {resp_q[38:0], 1'b0};
        cnt_d = cnt_q + 7'd1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      resp_q <= '0;
      cnt_q <= '0;
      long_q <= 1'b0;
      do_q <= 1'b1;
      valid_q <= 1'b0;
      card_q <= ST_UNINIT;
      app_q <= 1'b0;
      busy_q <= 8'(ACMD41_BUSY);
      idx_q <= '0;
      arg_q <= '0;
    end else begin
      frame_q <= frame_d;
      resp_q <= resp_d;
      cnt_q <= cnt_d;
      long_q <= long_d;
      do_q <= do_d;
      valid_q <= valid_d;
      card_q <= card_d;
      app_q <= app_d;
      busy_q <= busy_d;
      idx_q <= idx_d;
      arg_q <= arg_d;
    end
  end
  assign DO = do_q;
  assign cmdValid = valid_q;
  assign cmdIndex = idx_q;
  assign cmdArgument = arg_q;
  assign cardState = card_q;
endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb_sd_spi_card_responder: directed SPI host driving the SD card responder
module tb_sd_spi_card_responder;
  logic clk = 1'b0, reset = 1'b1, SCLK = 1'b0, CS = 1'b1, CS2 = 1'b1, DI = 1'b1, sel = 1'b0;
  logic DO, DO2, cmdValid, cmdValid2;
  logic [5:0] cmdIndex, cmdIndex2;
  logic [31:0] cmdArgument, cmdArgument2;
  logic [1:0] cardState, cardState2;
  int checks = 0, errors = 0, vcnt = 0;
  logic [7:0] ncr;
  logic [39:0] rsp;
  always #5 clk = ~clk;
  always @(posedge clk) if (cmdValid) vcnt <= vcnt + 1;
  sd_spi_card_responder u_dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .DI(DI), .DO(DO),
    .cmdValid(cmdValid), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument), .cardState(cardState)
  );
  sd_spi_card_responder #(.CHECK_CRC(1)) u_dut_crc (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS2), .DI(DI), .DO(DO2),
    .cmdValid(cmdValid2), .cmdIndex(cmdIndex2), .cmdArgument(cmdArgument2), .cardState(cardState2)
  );
  task automatic bit_x(input logic b, output logic r);
    DI = b;
    #50;
    SCLK = 1'b1;
    r = sel ? DO2 : DO;
    #50;
    SCLK = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_x(t[i], b);
      r[i] = b;
    end
  endtask
  task automatic cmd(input logic [47:0] f, input int n, output logic [7:0] nb, output logic [39:0] r);
    logic [7:0] b;
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], b);
    xfer(8'hFF, nb);
    r = '0;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, b);
      r = {r[31:0], b};
    end
    xfer(8'hFF, b);
  endtask
  task automatic test_reset;
    checks += 3;
    if (DO !== 1'b1) begin errors++; $display("FAIL reset_do: got %b expected 1", DO); end
    if (cardState !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", cardState); end
    if ({cmdValid, cmdIndex, cmdArgument} !== 39'h0) begin errors++; $display("FAIL reset_cmd: got %b/%h/%h expected 0", cmdValid, cmdIndex, cmdArgument); end
  endtask
  task automatic test_uninit;
    cmd(48'h48_000001AA_87, 5, ncr, rsp);
    checks += 3;
    if ({ncr, rsp} !== 48'hFF_FFFFFFFFFF) begin errors++; $display("FAIL uninit_silent: got %h expected ffffffffffff", {ncr, rsp}); end
    if (cardState !== 2'd0) begin errors++; $display("FAIL uninit_state: got %0d expected 0", cardState); end
    if (vcnt !== 0) begin errors++; $display("FAIL uninit_valid: got %0d expected 0", vcnt); end
  endtask
  task automatic test_cs_abort;
    logic [47:0] f;
    logic b;
    f = 48'h40_00000000_95;
    for (int i = 47; i > 27; i--) bit_x(f[i], b);
    CS = 1'b1;
    #400;
    CS = 1'b0;
    #400;
    checks += 1;
    if (cardState !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", cardState); end
    cmd(f, 1, ncr, rsp);
    checks += 4;
    if (ncr !== 8'hFF) begin errors++; $display("FAIL cmd0_ncr: got %h expected ff", ncr); end
    if (rsp !== 40'h01) begin errors++; $display("FAIL cmd0_r1: got %h expected 01", rsp); end
    if (cardState !== 2'd1) begin errors++; $display("FAIL cmd0_state: got %0d expected 1", cardState); end
    if (vcnt !== 1 || cmdIndex !== 6'd0) begin errors++; $display("FAIL cmd0_valid: got %0d/%0d expected 1/0", vcnt, cmdIndex); end
  endtask
  task automatic test_cmd8;
    cmd(48'h48_000001AA_87, 5, ncr, rsp);
    checks += 2;
    if (rsp !== 40'h01_000001AA) begin errors++; $display("FAIL cmd8_r7: got %h expected 01000001aa", rsp); end
    if (cmdIndex !== 6'd8 || cmdArgument !== 32'h1AA) begin errors++; $display("FAIL cmd8_latch: got %0d/%h expected 8/000001aa", cmdIndex, cmdArgument); end
    cmd(48'h48_00000000_FF, 5, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h01_00000000) begin errors++; $display("FAIL cmd8_bad_vhs: got %h expected 0100000000", rsp); end
    cmd(48'h7A_00000000_FD, 5, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h01_00FF8000) begin errors++; $display("FAIL cmd58_idle: got %h expected 0100ff8000", rsp); end
  endtask
  task automatic test_acmd41;
    logic [7:0] exp_r [3] = '{8'h01, 8'h01, 8'h00};
    for (int k = 0; k < 3; k++) begin
      cmd(48'h77_00000000_65, 1, ncr, rsp);
      checks += 1;
      if (rsp !== 40'h01) begin errors++; $display("FAIL cmd55_%0d: got %h expected 01", k, rsp); end
      cmd(48'h69_40000000_77, 1, ncr, rsp);
      checks += 1;
      if (rsp[7:0] !== exp_r[k]) begin errors++; $display("FAIL acmd41_%0d: got %h expected %h", k, rsp[7:0], exp_r[k]); end
    end
    checks += 1;
    if (cardState !== 2'd2) begin errors++; $display("FAIL ready_state: got %0d expected 2", cardState); end
    cmd(48'h69_40000000_77, 1, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h04) begin errors++; $display("FAIL cmd41_no_app: got %h expected 04", rsp); end
  endtask
  task automatic test_ready_cmds;
    cmd(48'h7A_00000000_FD, 5, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h00_C0FF8000) begin errors++; $display("FAIL cmd58_ready: got %h expected 00c0ff8000", rsp); end
    cmd(48'h50_00000200_FF, 1, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h00) begin errors++; $display("FAIL cmd16_512: got %h expected 00", rsp); end
    cmd(48'h50_00000400_FF, 1, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h40) begin errors++; $display("FAIL cmd16_1024: got %h expected 40", rsp); end
    cmd(48'h51_00000000_FF, 1, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h04) begin errors++; $display("FAIL cmd17_illegal: got %h expected 04", rsp); end
  endtask
  task automatic test_bad_frame;
    int v0;
    v0 = vcnt;
    cmd(48'h50_00000200_00, 1, ncr, rsp);
    checks += 2;
    if ({ncr, rsp[7:0]} !== 16'hFFFF) begin errors++; $display("FAIL bad_end_bit: got %h expected ffff", {ncr, rsp[7:0]}); end
    if (vcnt !== v0) begin errors++; $display("FAIL bad_valid: got %0d expected %0d", vcnt, v0); end
  endtask
  task automatic test_reset_mid;
    logic [47:0] f;
    logic [7:0] b;
    logic x;
    f = 48'h7A_00000000_FD;
    for (int i = 5; i >= 0; i--) xfer(f[i*8 +: 8], b);
    xfer(8'hFF, b);
    bit_x(1'b1, x);
    bit_x(1'b1, x);
    #30;
    checks += 1;
    if (DO !== 1'b0) begin errors++; $display("FAIL mid_resp_do: got %b expected 0", DO); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (DO !== 1'b1) begin errors++; $display("FAIL mid_reset_do: got %b expected 1", DO); end
    if (cardState !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", cardState); end
    reset = 1'b0;
    #200;
    cmd(48'h40_00000000_95, 1, ncr, rsp);
    checks += 1;
    if (rsp !== 40'h01 || cardState !== 2'd1) begin errors++; $display("FAIL post_reset_cmd0: got %h/%0d expected 01/1", rsp, cardState); end
  endtask
  task automatic test_crc;
    CS = 1'b1;
    sel = 1'b1;
    CS2 = 1'b0;
    #200;
    cmd(48'h40_00000000_41, 1, ncr, rsp);
    checks += 2;
    if (rsp !== 40'h09) begin errors++; $display("FAIL crc_bad_r1: got %h expected 09", rsp); end
    if (cardState2 !== 2'd0) begin errors++; $display("FAIL crc_bad_state: got %0d expected 0", cardState2); end
    cmd(48'h40_00000000_95, 1, ncr, rsp);
    checks += 2;
    if (rsp !== 40'h01) begin errors++; $display("FAIL crc_good_r1: got %h expected 01", rsp); end
    if (cardState2 !== 2'd1) begin errors++; $display("FAIL crc_good_state: got %0d expected 1", cardState2); end
    CS2 = 1'b1;
    sel = 1'b0;
  endtask
  initial begin
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #20;
    test_reset;
    CS = 1'b0;
    #200;
    test_uninit;
    test_cs_abort;
    test_cmd8;
    test_acmd41;
    test_ready_cmds;
    test_bad_frame;
    test_reset_mid;
    test_crc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
